mem_port_arbiter: RTL and testbench

//  Shares one single-ported backing memory (memory2c-style) between the instruction-fetch

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_lat_counter.sv | 39 +++
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and defaults for the memory port arbiter
//
// Purpose: arbiter FSM state encodings, port-owner encodings and default
// parameter values shared by mem_port_arbiter and its latency counter.
// Ports: none (package).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int MEM_LAT_DEF = 1;
  localparam int D_BURST_DEF = 4;
  // Wide enough for MEM_LAT-1 with MEM_LAT up to 7.
  localparam int LAT_W       = 3;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// rtl/mem_port_arbiter_lat_counter.sv - loadable down-counter with zero flag (arb_lat_counter)
//
// Purpose: counts the remaining memory-latency cycles of the access in flight.
// Ports:
//   clk         in  core clock
//   rst         in  synchronous active-high reset (count -> 0)
//   i_load      in  load i_load_val this cycle (takes precedence over i_dec)
//   i_load_val  in  value to load
//   i_dec       in  decrement by one; saturates at zero
//   o_count     out current count
//   o_zero      out count == 0
module arb_lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_count = r_cnt;
  assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of a single-ported unified memory
//
// Purpose: serialises instruction-fetch and data accesses onto one backing
// memory, one access at a time (IDLE -> ISSUE -> WAIT -> DONE). Data has
// priority over fetch. Optional build macro ARB_FAIRNESS_EN adds a d_run
// counter that hands one grant to fetch after D_BURST consecutive data
// grants made while fetch was waiting.
// Ports:
//   clk, rst                     core clock, synchronous active-high reset
//   if_req/if_addr               fetch request and byte address
//   if_rdata/if_valid/if_stall   fetched word, one-cycle done pulse, stall
//   d_req/d_we/d_addr/d_wdata    data request, store flag, address, store data
//   d_rdata/d_valid/d_stall      load data, one-cycle done pulse, stall
//   mem_en/mem_wr                one-cycle access strobe and write qualifier
//   mem_addr/mem_wdata           registered access address and write data
//   mem_rdata                    memory read data, valid MEM_LAT cycles after mem_en
// A requester sees its valid pulse in the DONE cycle; whatever its req line
// shows in that cycle is treated as the next request, so it must drop or
// replace the request as soon as it sees valid.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int D_BURST = D_BURST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 7 || D_BURST < 1 || D_BURST > 7) begin : g_param_check
    $error("mem_port_arbiter: MEM_LAT and D_BURST must be in 1..7");
  end

  arb_state_t r_state;
  owner_t     r_owner;
  logic       r_we;
  logic       r_if_valid;
  logic       r_d_valid;
  logic       r_mem_en;
  logic       r_mem_wr;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic w_arb;
  logic w_gnt_d;
  logic w_gnt_if;
  logic w_lat_load;
  logic w_lat_dec;
  logic w_lat_zero;
  logic [LAT_W-1:0] w_lat_count;

  // Arbitration happens in IDLE and also in DONE so a queued request issues
  // right after the previous access without an idle bubble.
  assign w_arb = (r_state == ARB_IDLE) || (r_state == ARB_DONE);

`ifdef ARB_FAIRNESS_EN
  logic [2:0] r_d_run;
  logic       w_force_if;

  assign w_force_if = if_req && (r_d_run == 3'(D_BURST));
  assign w_gnt_d    = d_req && !w_force_if;

  // Counts data grants that starved a waiting fetch; any other grant restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_run <= 3'd0;
    end else if (w_arb && (d_req || if_req)) begin
      r_d_run <= (w_gnt_d && if_req) ? r_d_run + 3'd1 : 3'd0;
    end
  end
`else
  assign w_gnt_d = d_req;
`endif

  assign w_gnt_if = if_req && !w_gnt_d;

  assign w_lat_load = (r_state == ARB_ISSUE);
  assign w_lat_dec  = (r_state == ARB_WAIT);

  arb_lat_counter #(.W(LAT_W)) u_lat_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_lat_load),
    .i_load_val (LAT_W'(MEM_LAT - 1)),
    .i_dec      (w_lat_dec),
    .o_count    (w_lat_count),
    .o_zero     (w_lat_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_owner     <= OWN_IF;
      r_we        <= 1'b0;
      r_if_valid  <= 1'b0;
      r_d_valid   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_if_rdata  <= 32'd0;
      r_d_rdata   <= 32'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_wr   <= 1'b0;
      case (r_state)
        ARB_IDLE, ARB_DONE: begin
          if (w_gnt_d) begin
            r_owner     <= OWN_D;
            r_we        <= d_we;
            r_mem_en    <= 1'b1;
            r_mem_wr    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_state     <= ARB_ISSUE;
          end else if (w_gnt_if) begin
            r_owner     <= OWN_IF;
            r_we        <= 1'b0;
            r_mem_en    <= 1'b1;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= 32'd0;
            r_state     <= ARB_ISSUE;
          end else begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_ISSUE: begin
          r_state <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (w_lat_zero) begin
            if (r_owner == OWN_IF) begin
              r_if_rdata <= mem_rdata;
              r_if_valid <= 1'b1;
            end else begin
              if (!r_we) begin
                r_d_rdata <= mem_rdata;
              end
              r_d_valid <= 1'b1;
            end
            r_state <= ARB_DONE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign if_stall  = if_req && !r_if_valid;
  assign d_rdata   = r_d_rdata;
  assign d_valid   = r_d_valid;
  assign d_stall   = d_req && !r_d_valid;
  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  logic w_unused;
  assign w_unused = ^w_lat_count;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: MEM_LAT = 1
  logic        rst, if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_if_valid, a_if_stall, a_d_valid, a_d_stall, a_mem_en, a_mem_wr;

  // DUT B: MEM_LAT = 4, fetch port only exercised
  logic        b_rst, b_if_req, b_d_req, b_d_we;
  logic [31:0] b_if_addr, b_d_addr, b_d_wdata;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_if_valid, b_if_stall, b_d_valid, b_d_stall, b_mem_en, b_mem_wr;

  mem_port_arbiter #(.MEM_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(a_if_rdata),
    .if_valid(a_if_valid), .if_stall(a_if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(a_d_rdata), .d_valid(a_d_valid), .d_stall(a_d_stall),
    .mem_en(a_mem_en), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.MEM_LAT(4)) u_dut_b (
    .clk(clk), .rst(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata),
    .if_valid(b_if_valid), .if_stall(b_if_stall),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_valid(b_d_valid), .d_stall(b_d_stall),
    .mem_en(b_mem_en), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Backing memory: fixed contents plus one writable word. Read data is
  // poisoned outside its valid cycle so capture timing is exercised.
  localparam logic [31:0] POISON = 32'hBAD0BAD0;
  logic [31:0] st_addr = 32'd0;
  logic [31:0] st_data = 32'd0;
  logic        st_vld  = 1'b0;
  logic [31:0] pb [0:3];

  function automatic logic [31:0] rd_word(input logic [31:0] addr);
    if (st_vld && addr == st_addr) return st_data;
    case (addr)
      32'h10:  return 32'h00A00093;
      32'h20:  return 32'h00100113;
      32'h400: return 32'h11223344;
      default: return {addr[15:0], 16'hC0DE};
    endcase
  endfunction

  always @(posedge clk) begin
    if (a_mem_en && a_mem_wr) begin
      st_addr <= a_mem_addr;
      st_data <= a_mem_wdata;
      st_vld  <= 1'b1;
    end
    a_mem_rdata <= (a_mem_en && !a_mem_wr) ? rd_word(a_mem_addr) : POISON;
    pb[0] <= (b_mem_en && !b_mem_wr) ? rd_word(b_mem_addr) : POISON;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
    pb[3] <= pb[2];
  end
  assign b_mem_rdata = pb[3];

  int total = 0;
  int bad   = 0;
  bit fair;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ARB_FAIRNESS_EN
    fair = 1'b1;
`else
    fair = 1'b0;
`endif
    rst = 1'b1; if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    b_rst = 1'b1; b_if_req = 1'b0; b_if_addr = 32'd0;
    b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = 32'd0; b_d_wdata = 32'd0;
    a_mem_rdata = POISON;
    for (int i = 0; i < 4; i++) pb[i] = POISON;

    // Reset held two cycles with a fetch pending
    if_req = 1'b1; if_addr = 32'h10;
    tick; tick;
    chk("rst_mem_en",   a_mem_en,   0);
    chk("rst_if_valid", a_if_valid, 0);
    chk("rst_if_rdata", a_if_rdata, 0);
    chk("rst_d_rdata",  a_d_rdata,  0);
    chk("rst_mem_addr", a_mem_addr, 0);
    chk("rst_if_stall", a_if_stall, 1);

    // Lone fetch, MEM_LAT=1: IDLE(t) ISSUE(t+1) WAIT(t+2) DONE(t+3)
    rst = 1'b0;
    #1 chk("t0_if_stall", a_if_stall, 1);
    tick;
    chk("t1_mem_en",   a_mem_en,   1);
    chk("t1_mem_addr", a_mem_addr, 32'h10);
    chk("t1_mem_wr",   a_mem_wr,   0);
    chk("t1_if_stall", a_if_stall, 1);
    tick;
    chk("t2_mem_en",   a_mem_en,   0);
    chk("t2_if_valid", a_if_valid, 0);
    chk("t2_if_stall", a_if_stall, 1);
    tick;
    chk("t3_if_valid", a_if_valid, 1);
    chk("t3_if_rdata", a_if_rdata, 32'h00A00093);
    chk("t3_if_stall", a_if_stall, 0);
    if_req = 1'b0;
    tick;
    chk("t4_if_valid", a_if_valid, 0);
    chk("t4_if_hold",  a_if_rdata, 32'h00A00093);
    chk("t4_mem_en",   a_mem_en,   0);

    // Simultaneous load and fetch: data first, fetch issued without a bubble
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    #1 chk("tie_d_stall", a_d_stall, 1);
    tick;
    chk("tie_mem_en",   a_mem_en,   1);
    chk("tie_mem_addr", a_mem_addr, 32'h400);
    tick; tick;
    chk("tie_d_valid",  a_d_valid,  1);
    chk("tie_d_rdata",  a_d_rdata,  32'h11223344);
    chk("tie_if_valid", a_if_valid, 0);
    chk("tie_d_stall0", a_d_stall,  0);
    chk("tie_if_stall", a_if_stall, 1);
    d_req = 1'b0;
    tick;
    chk("tie_f_mem_en",  a_mem_en,   1);
    chk("tie_f_addr",    a_mem_addr, 32'h20);
    chk("tie_d_valid0",  a_d_valid,  0);
    tick; tick;
    chk("tie_f_if_valid", a_if_valid, 1);
    chk("tie_f_if_rdata", a_if_rdata, 32'h00100113);
    if_req = 1'b0;
    tick;

    // Store: one write strobe, d_rdata unchanged
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h404; d_wdata = 32'hDEADBEEF;
    tick;
    chk("st_mem_en",    a_mem_en,    1);
    chk("st_mem_wr",    a_mem_wr,    1);
    chk("st_mem_addr",  a_mem_addr,  32'h404);
    chk("st_mem_wdata", a_mem_wdata, 32'hDEADBEEF);
    tick;
    chk("st_wait_en", {a_mem_en, a_mem_wr}, 0);
    tick;
    chk("st_d_valid", a_d_valid, 1);
    chk("st_d_rdata", a_d_rdata, 32'h11223344);
    d_req = 1'b0; d_we = 1'b0;
    tick;
    // Read the stored word back
    d_req = 1'b1; d_addr = 32'h404;
    tick;
    chk("rb_mem_wr", a_mem_wr, 0);
    tick; tick;
    chk("rb_d_valid", a_d_valid, 1);
    chk("rb_d_rdata", a_d_rdata, 32'hDEADBEEF);
    d_req = 1'b0;
    tick;

    // Both ports held: strict priority, or one fetch after 4 data grants
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    if_req = 1'b1; if_addr = 32'h20;
    for (int g = 0; g < 6; g++) begin
      bit exp_if;
      exp_if = fair && (g == 4);
      tick;
      chk($sformatf("hold_g%0d_mem_en", g), a_mem_en, 1);
      chk($sformatf("hold_g%0d_addr", g), a_mem_addr, exp_if ? 32'h20 : 32'h400);
      tick; tick;
      chk($sformatf("hold_g%0d_valid", g), {a_if_valid, a_d_valid}, exp_if ? 2'b10 : 2'b01);
    end
    d_req = 1'b0; if_req = 1'b0;
    tick;
    chk("hold_end_mem_en", a_mem_en, 0);

    // MEM_LAT=4: reset in the WAIT cycle with lat_cnt=2 aborts the access
    b_rst = 1'b0; b_if_req = 1'b1; b_if_addr = 32'h10;
    tick;
    chk("b_issue_mem_en", b_mem_en, 1);
    tick;
    tick;
    b_rst = 1'b1;
    tick;
    chk("b_rst_mem_en",   b_mem_en,   0);
    chk("b_rst_if_valid", b_if_valid, 0);
    chk("b_rst_if_rdata", b_if_rdata, 0);
    chk("b_rst_mem_addr", b_mem_addr, 0);
    chk("b_rst_if_stall", b_if_stall, 1);
    b_rst = 1'b0; b_if_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      chk($sformatf("b_quiet_%0d", k), {b_if_valid, b_mem_en}, 0);
    end
    // Full MEM_LAT=4 fetch: valid exactly 6 cycles after the request
    b_if_req = 1'b1; b_if_addr = 32'h20;
    for (int k = 1; k <= 6; k++) begin
      tick;
      chk($sformatf("b_lat_c%0d", k), {b_if_valid, b_mem_en}, {k == 6, k == 1});
    end
    chk("b_lat_rdata", b_if_rdata, 32'h00100113);
    b_if_req = 1'b0;
    tick;
    chk("b_lat_end", b_if_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
